mux_arbiter_4x1: RTL and testbench
==================================

# mux_arbiter_4x1

Round-robin arbiter and output register in front of the 4-input, 4-bit select datapath. It shares one output channel between four requesters. Each cycle it picks one pending requester and acknowledges it, then captures that requester's data into a registered output with a valid/ready handshake. It drives the registered select so downstream logic knows which source produced each beat.

## Interface
Parameters:
- DATA_W, 4, width of each data input and of out_data
- BURST_LEN, 4, maximum consecutive beats one owner may hold priority; used only with ARB_BURST_EN; legal range 1..15

Ports:
- clk  input  1  rising-edge clock; the block has one clock
- rst_n  input  1  asynchronous active-low reset
- req  input  4  req[i]=1: data_in_i holds a valid beat
- data_in_0..data_in_3  input  DATA_W each  requester data
- ack  output  4  one-hot or zero, combinational; ack[i]=1 means data_in_i is captured at this clock edge
- out_data  output  DATA_W  registered selected data
- out_sel  output  2  registered index of the source of out_data
- out_valid  output  1  out_data/out_sel valid
- out_ready  input  1  downstream accepts the beat when out_valid && out_ready

## Operation
- Output register plus pointer ptr (2 bits, last winner).
- load_en = !out_valid || out_ready.
- Each cycle with load_en && |req && rst_n:
  - winner w = first i with req[i]=1, searched in order ptr+1, ptr+2, ptr+3, ptr (mod 4).
  - ack[w]=1.
  - At the edge: out_data<=data_in_w, out_sel<=w, out_valid<=1, ptr<=w.
- load_en && !|req: out_valid<=0 at the edge, ack=0. out_data and out_sel hold their values.
- !load_en (out_valid && !out_ready): ack=0; out_data, out_sel, out_valid and ptr all hold.
- Requester protocol: data_in_i must be stable while req[i]=1 && !ack[i]. After ack[i], the requester may drop req[i] or present the next beat with req[i] still high in the following cycle.
- Output data is never modified while out_valid=1 and out_ready=0.
- ack is forced to 0 while rst_n=0.
- Reset values: out_valid=0, out_data=0, out_sel=0, ptr=3 (requester 0 has highest priority first), burst counter=0.

## Timing
- Capture latency: a beat acknowledged at edge k appears on out_data with out_valid=1 after edge k.
- Throughput: 1 beat/cycle sustained with out_ready held high.
- Backpressure: out_ready=0 stalls arbitration. ptr does not advance, so no requester loses its turn.
- Simultaneous drain and refill (out_valid && out_ready && |req): the new beat loads in the same cycle, with no bubble.
- Reset asserted mid-transfer: outputs clear immediately (asynchronously) and the in-flight beat is dropped. After release, the first grant goes to the lowest-index requester.
- A single persistent requester wins every cycle, because ptr is the last entry in the search order.

## Configuration
- ARB_BURST_EN defined:
  - A 4-bit counter cnt tracks consecutive wins by ptr.
  - If req[ptr]=1 and cnt < BURST_LEN-1, then w=ptr and cnt increments.
  - Otherwise normal round-robin applies and cnt<=0 on a new owner.
  - BURST_LEN=1 behaves identically to the undefined case.
- ARB_BURST_EN undefined: no counter; strict round-robin, and the pointer advances on every capture.

## Structure
- Package mux_arb_pkg:
  - N_SRC=4, SEL_W=2
  - a function returning the rotated one-hot priority pick from (req, ptr)
- Sub-module rr_pick_4: purely combinational. Inputs req[3:0] and ptr[1:0]; outputs any, w[1:0] and onehot[3:0]. It is instantiated once.
- The top level holds the output register, ptr, the optional burst counter, and the data mux selected by w.

## Test plan
- Reset, then req=4'b1111 with out_ready=1 and data_in_i=i+1 (ARB_BURST_EN off) -> out_sel sequence 0,1,2,3,0; out_data 1,2,3,4,1; one beat per cycle; ack one-hot each cycle.
- Only req[2] held for 5 cycles, out_ready=1 -> ack=4'b0100 every cycle, 5 beats with out_sel=2, no bubbles.
- Beat loaded from source 1, then out_ready=0 for 3 cycles with req=4'b1111 -> ack=0; out_data, out_sel and out_valid stable. With out_ready=1, the next out_sel=2.
- req drops to 0 while out_valid=1 and out_ready=1 -> out_valid=0 the next cycle; out_data holds its last value.
- rst_n pulsed low while out_valid=1 and req=4'b1010 -> out_valid, out_data and out_sel are 0 immediately. The first ack after release is 4'b0010.
- ARB_BURST_EN with BURST_LEN=3 and req=4'b0011 held, out_ready=1 -> out_sel 0,0,0,1,1,1,0.

Source files
------------

// File: rtl/mux_arb_pkg.sv
// rtl/mux_arb_pkg.sv - shared sizes and rotated priority pick for the 4:1 arbiter
// Contents:
//   N_SRC      number of requesters
//   SEL_W      width of a requester index
//   rr_onehot  one-hot winner: first set req bit searched from ptr+1 up to ptr (mod N_SRC)
package mux_arb_pkg;

    localparam int N_SRC = 4;
    localparam int SEL_W = 2;

    function automatic logic [N_SRC-1:0] rr_onehot(
        input logic [N_SRC-1:0] req,
        input logic [SEL_W-1:0] ptr
    );
        logic [N_SRC-1:0] pick;
        logic [SEL_W-1:0] idx;
        pick = '0;
        // k = N_SRC wraps back to ptr itself, so the last winner is searched last
        for (int k = 1; k <= N_SRC; k++) begin
            idx = ptr + SEL_W'(k);
            if (req[idx] && (pick == '0)) begin
                pick[idx] = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/rr_pick_4.sv
// rtl/rr_pick_4.sv - combinational round-robin pick over four requesters
// Ports:
//   req     in   [3:0]  pending requests
//   ptr     in   [1:0]  last winner; search starts at ptr+1
//   any     out         at least one request pending
//   w       out  [1:0]  index of the winner (0 when none)
//   onehot  out  [3:0]  one-hot winner (0 when none)
module rr_pick_4
    import mux_arb_pkg::*;
(
    input  logic [N_SRC-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic             any,
    output logic [SEL_W-1:0] w,
    output logic [N_SRC-1:0] onehot
);

    always_comb begin
        onehot = rr_onehot(req, ptr);
        any    = |req;
        w      = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (onehot[i]) begin
                w = SEL_W'(i);
            end
        end
    end

endmodule

// File: rtl/mux_arbiter_4x1.sv
// rtl/mux_arbiter_4x1.sv - round-robin 4:1 arbiter with registered valid/ready output
// Optional feature macro: ARB_BURST_EN (owner may keep priority for up to BURST_LEN beats)
// Ports:
//   clk         in                rising-edge clock
//   rst_n       in                asynchronous active-low reset
//   req         in   [3:0]        req[i]=1: data_in_i holds a valid beat
//   data_in_0..3 in  [DATA_W-1:0] requester data
//   ack         out  [3:0]        one-hot or zero; data_in_i captured at this edge
//   out_data    out  [DATA_W-1:0] registered selected data
//   out_sel     out  [1:0]        registered source index of out_data
//   out_valid   out               out_data/out_sel valid
//   out_ready   in                downstream accepts when out_valid && out_ready
module mux_arbiter_4x1
    import mux_arb_pkg::*;
#(
    parameter int DATA_W    = 4,
    parameter int BURST_LEN = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_SRC-1:0]  req,
    input  logic [DATA_W-1:0] data_in_0,
    input  logic [DATA_W-1:0] data_in_1,
    input  logic [DATA_W-1:0] data_in_2,
    input  logic [DATA_W-1:0] data_in_3,
    output logic [N_SRC-1:0]  ack,
    output logic [DATA_W-1:0] out_data,
    output logic [SEL_W-1:0]  out_sel,
    output logic              out_valid,
    input  logic              out_ready
);

    logic [SEL_W-1:0]  ptr;
    logic [SEL_W-1:0]  pick_w;
    logic [SEL_W-1:0]  w;
    logic [N_SRC-1:0]  pick_oh;
    logic [N_SRC-1:0]  win_oh;
    logic              any;
    logic              load_en;
    logic              capture;
    logic [DATA_W-1:0] sel_data;

    rr_pick_4 u_pick (
        .req    (req),
        .ptr    (ptr),
        .any    (any),
        .w      (pick_w),
        .onehot (pick_oh)
    );

`ifdef ARB_BURST_EN
    localparam logic [3:0] BURST_MAX = 4'(BURST_LEN - 1);

    logic [3:0] cnt;
    logic       hold;

    // The current owner keeps the grant while it still requests and has burst budget left
    always_comb begin
        hold   = req[ptr] && (cnt < BURST_MAX);
        w      = hold ? ptr : pick_w;
        win_oh = hold ? (N_SRC'(1) << ptr) : pick_oh;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (capture) begin
            cnt <= hold ? cnt + 4'd1 : 4'd0;
        end
    end
`else
    localparam int unused_burst_len = BURST_LEN;

    always_comb begin
        w      = pick_w;
        win_oh = pick_oh;
    end
`endif

    assign load_en = !out_valid || out_ready;
    // rst_n gates the grant so no requester sees an ack that the held-in-reset register drops
    assign capture = rst_n && load_en && any;
    assign ack     = capture ? win_oh : '0;

    always_comb begin
        sel_data = data_in_0;
        case (w)
            2'd0: sel_data = data_in_0;
            2'd1: sel_data = data_in_1;
            2'd2: sel_data = data_in_2;
            2'd3: sel_data = data_in_3;
            default: sel_data = data_in_0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data  <= '0;
            out_sel   <= '0;
            out_valid <= 1'b0;
            ptr       <= 2'd3;
        end else if (load_en) begin
            if (any) begin
                out_data  <= sel_data;
                out_sel   <= w;
                out_valid <= 1'b1;
                ptr       <= w;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mux_arbiter_4x1.sv
// tb/tb_mux_arbiter_4x1.sv - table-driven check of mux_arbiter_4x1
module tb_mux_arbiter_4x1;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] data_in_0;
    logic [3:0] data_in_1;
    logic [3:0] data_in_2;
    logic [3:0] data_in_3;
    logic [3:0] ack;
    logic [3:0] out_data;
    logic [1:0] out_sel;
    logic       out_valid;
    logic       out_ready;

    int total;
    int bad;

    typedef struct {
        logic [3:0] req;
        logic       rdy;
        logic [3:0] ack;
        logic       valid;
        logic [1:0] sel;
        logic [3:0] data;
    } vec_t;

    vec_t vecs[$];

    mux_arbiter_4x1 #(.DATA_W(4), .BURST_LEN(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .data_in_0 (data_in_0),
        .data_in_1 (data_in_1),
        .data_in_2 (data_in_2),
        .data_in_3 (data_in_3),
        .ack       (ack),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic [3:0] r, input logic rdy, input logic [3:0] a,
                       input logic v, input logic [1:0] s, input logic [3:0] d);
        vec_t x;
        x.req = r; x.rdy = rdy; x.ack = a; x.valid = v; x.sel = s; x.data = d;
        vecs.push_back(x);
    endtask

    task automatic run_vec(input int i);
        @(negedge clk);
        req       = vecs[i].req;
        out_ready = vecs[i].rdy;
        #1;
        chk($sformatf("v%0d_ack", i), ack, vecs[i].ack);
        @(posedge clk);
        #1;
        chk($sformatf("v%0d_valid", i), out_valid, vecs[i].valid);
        chk($sformatf("v%0d_sel", i), out_sel, vecs[i].sel);
        chk($sformatf("v%0d_data", i), out_data, vecs[i].data);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        req   = 4'b0000;
        out_ready = 1'b0;
        data_in_0 = 4'd1;
        data_in_1 = 4'd2;
        data_in_2 = 4'd3;
        data_in_3 = 4'd4;

        repeat (2) @(negedge clk);
        chk("reset_valid", out_valid, 0);
        chk("reset_data", out_data, 0);
        chk("reset_sel", out_sel, 0);
        chk("reset_ack", ack, 0);
        rst_n = 1'b1;

`ifdef ARB_BURST_EN
        // BURST_LEN=3, two requesters: owner keeps three beats before rotating
        add(4'b0011, 1'b1, 4'b0001, 1'b1, 2'd0, 4'd1);
        add(4'b0011, 1'b1, 4'b0001, 1'b1, 2'd0, 4'd1);
        add(4'b0011, 1'b1, 4'b0001, 1'b1, 2'd0, 4'd1);
        add(4'b0011, 1'b1, 4'b0010, 1'b1, 2'd1, 4'd2);
        add(4'b0011, 1'b1, 4'b0010, 1'b1, 2'd1, 4'd2);
        add(4'b0011, 1'b1, 4'b0010, 1'b1, 2'd1, 4'd2);
        add(4'b0011, 1'b1, 4'b0001, 1'b1, 2'd0, 4'd1);
`else
        // all four requesting: strict rotation starting at requester 0
        add(4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 4'd1);
        add(4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 4'd2);
        add(4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 4'd3);
        add(4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, 4'd4);
        add(4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 4'd1);
        // single persistent requester wins every cycle
        for (int i = 0; i < 5; i++) add(4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2, 4'd3);
        // load from source 1, then stall three cycles, then resume at source 2
        add(4'b0010, 1'b1, 4'b0010, 1'b1, 2'd1, 4'd2);
        for (int i = 0; i < 3; i++) add(4'b1111, 1'b0, 4'b0000, 1'b1, 2'd1, 4'd2);
        add(4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 4'd3);
        // requests vanish while draining: valid drops, data/sel hold
        add(4'b0000, 1'b1, 4'b0000, 1'b0, 2'd2, 4'd3);
        add(4'b0000, 1'b0, 4'b0000, 1'b0, 2'd2, 4'd3);
        // refill from idle: ptr is 2, so requester 3 is next
        add(4'b1111, 1'b0, 4'b1000, 1'b1, 2'd3, 4'd4);
`endif

        foreach (vecs[i]) run_vec(i);

`ifndef ARB_BURST_EN
        // asynchronous reset while a beat is held, then first grant after release
        @(negedge clk);
        req       = 4'b1010;
        out_ready = 1'b0;
        #1;
        chk("pre_rst_ack", ack, 0);
        chk("pre_rst_valid", out_valid, 1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_sel", out_sel, 0);
        chk("rst_ack", ack, 0);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("post_rst_ack", ack, 4'b0010);
        @(posedge clk);
        #1;
        chk("post_rst_valid", out_valid, 1);
        chk("post_rst_sel", out_sel, 1);
        chk("post_rst_data", out_data, 2);
        @(negedge clk);
        #1;
        chk("post_rst_ack2", ack, 4'b1000);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
